usb2_ulpi_tx_arbiter: RTL and testbench
=======================================

Name: usb2_ulpi_tx_arbiter

Overview:
Arbitrates the single ULPI transmit path between two requesters. The first is the USB 2.0 packet layer, which sends handshake and data packets through TXCMD. The second is a PHY register-access client, which issues ULPI register writes and reads for PHY configuration. The block sits between the packet layer / PHY-config FSM and the ULPI pin interface, in the phy_clk domain. It sequences ULPI register transactions itself and passes packet bytes through transparently.

Parameters:
TIMEOUT, 255, max phy_clk cycles to wait for ulpi_nxt in any register-transaction state before aborting
TO_W, 8, width of the timeout counter; must hold TIMEOUT

Ports:
phy_clk  in  1  ULPI 60 MHz clock; the only clock
reset  in  1  synchronous, active-high reset
ulpi_dir  in  1  PHY owns bus when 1
ulpi_nxt  in  1  PHY next strobe
ulpi_din  in  8  ULPI data from PHY (valid when ulpi_dir=1)
ulpi_dout  out  8  ULPI data to PHY
ulpi_stp  out  1  ULPI stop
pkt_req  in  1  packet layer wants the bus; held high until pkt_stp
pkt_cts  out  1  packet layer granted and bus turned around (clear to send)
pkt_byte  in  8  packet byte; first byte is TXCMD 8'h4X
pkt_latch  in  1  pkt_byte valid
pkt_stp  in  1  packet layer end-of-packet stop
pkt_nxt  out  1  ulpi_nxt gated to packet layer
reg_req  in  1  one-cycle register request pulse; accepted only while reg_busy=0
reg_rd  in  1  1=read, 0=write (sampled with reg_req)
reg_addr  in  6  PHY register address (immediate addressing only)
reg_wdata  in  8  write data (sampled with reg_req)
reg_busy  out  1  register transaction pending or active
reg_done  out  1  one-cycle pulse on completion
reg_rdata  out  8  read result, valid from reg_done onward until the next reg_done
reg_err  out  1  one-cycle pulse (together with reg_done) on timeout abort

Behaviour:
- Reset values: ulpi_dout=0, ulpi_stp=0, pkt_cts=0, pkt_nxt=0, reg_busy=0, reg_done=0, reg_rdata=0, reg_err=0, state=IDLE, fair=0, timeout counter=0. Reset mid-transaction returns to IDLE the next cycle and drops the pending register request.
- reg_req with reg_busy=0 latches rd/addr/wdata and sets reg_busy the next cycle. reg_req while reg_busy=1 is ignored.
- States: IDLE, PKT, REG_CMD, REG_WDATA, REG_STP, REG_TURN, REG_RDATA, TURN.
- IDLE: no grant while ulpi_dir=1. Otherwise:
  - Packet pending only -> PKT.
  - Register pending only -> REG_CMD.
  - Both pending -> PKT if fair=0, else REG_CMD.
  - fair is set when a PKT grant completes with a register request still pending; it clears on entry to REG_CMD.
- PKT: pkt_cts=1.
  - ulpi_dout = pkt_latch ? pkt_byte : 0; ulpi_stp = pkt_stp; pkt_nxt = ulpi_nxt (all combinational).
  - pkt_stp -> TURN.
  - If ulpi_dir rises while in PKT, it is passed through and the packet layer handles the abort.
- REG_CMD: drive ulpi_dout = {rd ? 2'b11 : 2'b10, addr}.
  - If ulpi_dir=1 in this cycle: PHY abort; drive 0 -> IDLE with the request kept pending; no timeout count.
  - On ulpi_nxt: write -> REG_WDATA; read -> REG_TURN.
- REG_WDATA: drive wdata.
  - On ulpi_nxt -> REG_STP.
- REG_STP: ulpi_stp=1, ulpi_dout=0 for exactly 1 cycle.
  - Then reg_done pulse, reg_busy=0 -> TURN.
- REG_TURN: PHY turnaround cycle (ulpi_dir expected high); drive 0.
  - Next cycle -> REG_RDATA.
- REG_RDATA: sample reg_rdata <= ulpi_din.
  - Pulse reg_done, clear reg_busy -> TURN.
- TURN: one idle cycle, ulpi_dout=0, no grant -> IDLE. Back-to-back transactions are therefore spaced by at least 1 cycle.
- Timeout:
  - Counter resets on every state change and counts in REG_CMD/REG_WDATA while ulpi_nxt=0.
  - Reaching TIMEOUT -> REG_STP-like 1-cycle stp, then reg_done+reg_err together, reg_busy=0, reg_rdata unchanged -> TURN.
- ulpi_stp is 0 in all states except REG_STP, PKT pass-through, and timeout stp.
- pkt_nxt is 0 outside PKT.
- Latency: from register request to REG_CMD drive is 2 cycles (latch, then IDLE grant) when the bus is idle.
- Write transaction with immediate nxt: cmd, data, stp, done pulse = 4 cycles after REG_CMD entry.

Test Plan:
- Reg write addr 6'h0A data 8'h45, PHY asserts nxt on 1st and 2nd drive cycles -> ulpi_dout 8'h8A, 8'h45, then stp=1 with dout=0, reg_done 1 cycle later with reg_err=0; busy low after.
- Reg read addr 6'h04, PHY nxt on cmd, dir high next 2 cycles with din=8'h24 -> dout 8'hC4, reg_rdata=8'h24 at reg_done.
- pkt_req and reg_req same cycle, fair=0 -> packet granted first (pkt_cts=1, bytes 8'h4D, stp pass through). The register transaction starts after the TURN cycle, then fair clears.
- ulpi_dir=1 while in REG_CMD -> returns to IDLE, no reg_done, command reissued once dir falls, completes normally.
- Write with nxt never asserted, TIMEOUT=255 -> after 255 cycles in REG_CMD, one stp cycle, reg_done+reg_err pulse, reg_busy=0.
- Assert reset during REG_WDATA -> next cycle: state IDLE, reg_busy=0, ulpi_stp=0, no reg_done; a new request is accepted afterwards.

Source files
------------

// File: rtl/usb2_ulpi_tx_arbiter.sv
// ULPI transmit-path arbiter: shares the PHY link between the packet layer (TXCMD
// pass-through) and a register-access client, sequencing ULPI register reads and writes.
module usb2_ulpi_tx_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic       phy_clk,
  input  logic       reset,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_din,
  output logic [7:0] ulpi_dout,
  output logic       ulpi_stp,
  input  logic       pkt_req,
  output logic       pkt_cts,
  input  logic [7:0] pkt_byte,
  input  logic       pkt_latch,
  input  logic       pkt_stp,
  output logic       pkt_nxt,
  input  logic       reg_req,
  input  logic       reg_rd,
  input  logic [5:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic       reg_busy,
  output logic       reg_done,
  output logic [7:0] reg_rdata,
  output logic       reg_err,
  output logic [2:0] dbg_state
);

  // Handshake: reg_req is a single-cycle pulse taken only while reg_busy=0 and answered by
  // one reg_done pulse; pkt_req is held from request until pkt_stp, pkt_cts is the grant.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PKT       = 3'd1,
    S_REG_CMD   = 3'd2,
    S_REG_WDATA = 3'd3,
    S_REG_STP   = 3'd4,
    S_REG_TURN  = 3'd5,
    S_REG_RDATA = 3'd6,
    S_TURN      = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_fair;
  logic            r_busy;
  logic            r_rd;
  logic [5:0]      r_addr;
  logic [7:0]      r_wdata;
  logic [7:0]      r_rdata;
  logic            r_done;
  logic            r_err;
  logic            r_tmo;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_counting;
  logic            w_to_hit;

  // A PHY abort in REG_CMD (dir high) must not advance the timeout.
  assign w_counting = !ulpi_nxt &&
                      ((r_state == S_REG_CMD && !ulpi_dir) || r_state == S_REG_WDATA);
  assign w_to_hit   = w_counting && (r_to_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    w_next    = r_state;
    ulpi_dout = 8'h00;
    ulpi_stp  = 1'b0;
    pkt_cts   = 1'b0;
    pkt_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!ulpi_dir) begin
          if (pkt_req && (!r_busy || !r_fair)) w_next = S_PKT;
          else if (r_busy)                     w_next = S_REG_CMD;
        end
      end
      S_PKT: begin
        pkt_cts   = 1'b1;
        ulpi_dout = pkt_latch ? pkt_byte : 8'h00;
        ulpi_stp  = pkt_stp;
        pkt_nxt   = ulpi_nxt;
        if (pkt_stp) w_next = S_TURN;
      end
      S_REG_CMD: begin
        if (ulpi_dir) begin
          w_next = S_IDLE;
        end else begin
          ulpi_dout = {1'b1, r_rd, r_addr};
          if (ulpi_nxt)      w_next = r_rd ? S_REG_TURN : S_REG_WDATA;
          else if (w_to_hit) w_next = S_REG_STP;
        end
      end
      S_REG_WDATA: begin
        ulpi_dout = r_wdata;
        if (ulpi_nxt || w_to_hit) w_next = S_REG_STP;
      end
      S_REG_STP: begin
        ulpi_stp = 1'b1;
        w_next   = S_TURN;
      end
      S_REG_TURN:  w_next = S_REG_RDATA;
      S_REG_RDATA: w_next = S_TURN;
      S_TURN:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge phy_clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_fair   <= 1'b0;
      r_busy   <= 1'b0;
      r_rd     <= 1'b0;
      r_addr   <= 6'h00;
      r_wdata  <= 8'h00;
      r_rdata  <= 8'h00;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_tmo    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_to_cnt <= '0;
      else if (w_counting)   r_to_cnt <= r_to_cnt + TO_W'(1);
      // REG_STP lasts one cycle and is entered only from CMD/WDATA, so this marks a timeout stop.
      r_tmo  <= w_to_hit;
      r_done <= (r_state == S_REG_STP) || (r_state == S_REG_RDATA);
      r_err  <= (r_state == S_REG_STP) && r_tmo;
      if (!r_busy && reg_req) begin
        r_busy  <= 1'b1;
        r_rd    <= reg_rd;
        r_addr  <= reg_addr;
        r_wdata <= reg_wdata;
      end else if (r_state == S_REG_STP || r_state == S_REG_RDATA) begin
        r_busy <= 1'b0;
      end
      if (r_state == S_REG_RDATA) r_rdata <= ulpi_din;
      if (r_state == S_PKT && pkt_stp && r_busy)           r_fair <= 1'b1;
      else if (r_state == S_IDLE && w_next == S_REG_CMD)   r_fair <= 1'b0;
    end
  end

  assign reg_busy  = r_busy;
  assign reg_done  = r_done;
  assign reg_err   = r_err;
  assign reg_rdata = r_rdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_usb2_ulpi_tx_arbiter.sv
// Bench for usb2_ulpi_tx_arbiter: table of register transactions plus hand-written
// arbitration, PHY-abort, timeout and reset sequences, checked against an expected queue.
module tb_usb2_ulpi_tx_arbiter;

  localparam int         TIMEOUT     = 255;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PKT      = 3'd1;
  localparam logic [2:0] ST_TURN     = 3'd7;

  logic       phy_clk;
  logic       reset;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic [7:0] ulpi_din;
  logic [7:0] ulpi_dout;
  logic       ulpi_stp;
  logic       pkt_req;
  logic       pkt_cts;
  logic [7:0] pkt_byte;
  logic       pkt_latch;
  logic       pkt_stp;
  logic       pkt_nxt;
  logic       reg_req;
  logic       reg_rd;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_busy;
  logic       reg_done;
  logic [7:0] reg_rdata;
  logic       reg_err;
  logic [2:0] dbg_state;

  usb2_ulpi_tx_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .phy_clk   (phy_clk),
    .reset     (reset),
    .ulpi_dir  (ulpi_dir),
    .ulpi_nxt  (ulpi_nxt),
    .ulpi_din  (ulpi_din),
    .ulpi_dout (ulpi_dout),
    .ulpi_stp  (ulpi_stp),
    .pkt_req   (pkt_req),
    .pkt_cts   (pkt_cts),
    .pkt_byte  (pkt_byte),
    .pkt_latch (pkt_latch),
    .pkt_stp   (pkt_stp),
    .pkt_nxt   (pkt_nxt),
    .reg_req   (reg_req),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_busy  (reg_busy),
    .reg_done  (reg_done),
    .reg_rdata (reg_rdata),
    .reg_err   (reg_err),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic       rd;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] din;
    int         nxt_wait;
    logic [7:0] exp_cmd;
    logic [7:0] exp_res;
  } vec_t;

  localparam int NV = 10;
  vec_t       tv[NV];
  logic [7:0] exp_q[$];
  logic [7:0] last_rdata;
  int         n_checks;
  int         n_fail;

  // clock / reset
  initial begin
    phy_clk = 1'b0;
    forever #5 phy_clk = ~phy_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  task automatic tick();
    @(posedge phy_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic [5:0] addr, input logic [7:0] wdata,
                              input logic [7:0] din, input int nw, input logic [7:0] e_cmd,
                              input logic [7:0] e_res);
    vec_t v;
    v.rd = rd; v.addr = addr; v.wdata = wdata; v.din = din;
    v.nxt_wait = nw; v.exp_cmd = e_cmd; v.exp_res = e_res;
    return v;
  endfunction

  // driver: issue one request pulse and record what the bus must carry for it
  task automatic reg_issue(input logic rd, input logic [5:0] addr, input logic [7:0] wdata,
                           input logic [7:0] e_cmd, input logic [7:0] e_res);
    reg_req   = 1'b1;
    reg_rd    = rd;
    reg_addr  = addr;
    reg_wdata = wdata;
    exp_q.push_back(e_cmd);
    exp_q.push_back(e_res);
    tick();
    reg_req = 1'b0;
  endtask

  // PHY model: service a transaction starting at the cycle the command must be on the bus
  task automatic reg_service(input logic rd, input logic [7:0] din, input int nxt_wait);
    logic [7:0] e_cmd;
    logic [7:0] e_dat;
    int bad;
    e_cmd = exp_q.pop_front();
    e_dat = exp_q.pop_front();
    bad = 0;
    for (int c = 0; c <= nxt_wait; c++) begin
      ulpi_nxt = (c == nxt_wait);
      #2;
      if (c == 0) chk("cmd_byte", ulpi_dout, e_cmd);
      if (ulpi_dout !== e_cmd || ulpi_stp !== 1'b0 || pkt_cts !== 1'b0) bad++;
      tick();
    end
    chk("cmd_hold", bad, 0);
    ulpi_nxt = 1'b0;
    if (!rd) begin
      bad = 0;
      for (int c = 0; c <= nxt_wait; c++) begin
        ulpi_nxt = (c == nxt_wait);
        #2;
        if (c == 0) chk("wdata_byte", ulpi_dout, e_dat);
        if (ulpi_dout !== e_dat || ulpi_stp !== 1'b0) bad++;
        tick();
      end
      chk("wdata_hold", bad, 0);
      ulpi_nxt = 1'b0;
      #2;
      chk("stp_cycle", {ulpi_stp, ulpi_dout, reg_done}, {1'b1, 8'h00, 1'b0});
      tick();
    end else begin
      ulpi_dir = 1'b1;
      ulpi_din = 8'h00;
      #2;
      chk("rd_turn", {ulpi_stp, ulpi_dout}, 9'h000);
      tick();
      ulpi_din = din;
      #2;
      chk("rd_data_phase", {ulpi_stp, ulpi_dout, reg_done}, 10'h000);
      tick();
      ulpi_dir = 1'b0;
      ulpi_din = 8'h00;
    end
    #2;
    chk("done_pulse", {reg_done, reg_err, reg_busy, ulpi_stp}, 4'b1000);
    if (rd) begin
      chk("rdata", reg_rdata, e_dat);
      last_rdata = e_dat;
    end else begin
      chk("rdata_kept", reg_rdata, last_rdata);
    end
    tick();
    #2;
    chk("done_end", {reg_done, reg_busy}, 2'b00);
  endtask

  task automatic tmo_seq(input int stage, input logic [5:0] addr, input logic [7:0] wdata);
    logic [7:0] e_cmd;
    logic [7:0] e_dat;
    logic [7:0] e_drv;
    int bad;
    reg_issue(1'b0, addr, wdata, {2'b10, addr}, wdata);
    tick();
    e_cmd = exp_q.pop_front();
    e_dat = exp_q.pop_front();
    if (stage == 1) begin
      ulpi_nxt = 1'b1;
      #2;
      chk("tmo_cmd", ulpi_dout, e_cmd);
      tick();
      ulpi_nxt = 1'b0;
    end
    e_drv = (stage == 1) ? e_dat : e_cmd;
    bad = 0;
    for (int c = 0; c < TIMEOUT; c++) begin
      #2;
      if (ulpi_dout !== e_drv || ulpi_stp !== 1'b0 || reg_done !== 1'b0) bad++;
      tick();
    end
    chk("tmo_wait", bad, 0);
    #2;
    chk("tmo_stp", {ulpi_stp, ulpi_dout}, 9'h100);
    tick();
    #2;
    chk("tmo_done_err", {reg_done, reg_err, reg_busy}, 3'b110);
    chk("tmo_rdata_kept", reg_rdata, last_rdata);
    tick();
    #2;
    chk("tmo_err_end", {reg_done, reg_err}, 2'b00);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    last_rdata = 8'h00;
    reset = 1'b1;
    ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_din = 8'h00;
    pkt_req = 1'b0; pkt_byte = 8'h00; pkt_latch = 1'b0; pkt_stp = 1'b0;
    reg_req = 1'b0; reg_rd = 1'b0; reg_addr = 6'h00; reg_wdata = 8'h00;

    tv[0] = mk(1'b0, 6'h0A, 8'h45, 8'h00, 0, 8'h8A, 8'h45);
    tv[1] = mk(1'b1, 6'h04, 8'h00, 8'h24, 0, 8'hC4, 8'h24);
    tv[2] = mk(1'b0, 6'h3F, 8'hFF, 8'h00, 3, 8'hBF, 8'hFF);
    tv[3] = mk(1'b1, 6'h00, 8'h00, 8'hA5, 2, 8'hC0, 8'hA5);
    tv[4] = mk(1'b0, 6'h15, 8'h00, 8'h00, 1, 8'h95, 8'h00);
    tv[5] = mk(1'b1, 6'h2A, 8'h00, 8'h5A, 0, 8'hEA, 8'h5A);
    for (int i = 6; i < NV; i++) begin
      tv[i].rd       = 1'($urandom_range(0, 1));
      tv[i].addr     = 6'($urandom_range(0, 63));
      tv[i].wdata    = 8'($urandom_range(0, 255));
      tv[i].din      = 8'($urandom_range(0, 255));
      tv[i].nxt_wait = $urandom_range(0, 3);
      tv[i].exp_cmd  = {1'b1, tv[i].rd, tv[i].addr};
      tv[i].exp_res  = tv[i].rd ? tv[i].din : tv[i].wdata;
    end

    repeat (3) tick();
    #2;
    chk("reset_vals", {ulpi_dout, ulpi_stp, pkt_cts, pkt_nxt, reg_busy, reg_done,
                       reg_rdata, reg_err, dbg_state}, 32'h0);
    reset = 1'b0;
    tick();

    // table-driven register transactions
    for (int i = 0; i < NV; i++) begin
      reg_issue(tv[i].rd, tv[i].addr, tv[i].wdata, tv[i].exp_cmd, tv[i].exp_res);
      #2;
      chk("busy_set", {reg_busy, dbg_state}, {1'b1, ST_IDLE});
      tick();
      reg_service(tv[i].rd, tv[i].din, tv[i].nxt_wait);
    end

    // request while busy is ignored
    reg_issue(1'b0, 6'h0C, 8'h55, 8'h8C, 8'h55);
    reg_req = 1'b1; reg_rd = 1'b1; reg_addr = 6'h3F;
    #2;
    chk("busy_second_req", reg_busy, 1'b1);
    tick();
    reg_req = 1'b0;
    reg_service(1'b0, 8'h00, 0);
    tick();
    #2;
    chk("ignored_req", {dbg_state, reg_busy}, {ST_IDLE, 1'b0});

    // arbitration: both pending while PHY holds the bus, fair=0 -> packet first
    ulpi_dir = 1'b1; pkt_req = 1'b1;
    reg_req = 1'b1; reg_rd = 1'b0; reg_addr = 6'h01; reg_wdata = 8'h33;
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h33);
    #2;
    chk("arb_hold0", pkt_cts, 1'b0);
    tick();
    reg_req = 1'b0;
    #2;
    chk("arb_hold1", {pkt_cts, reg_busy, dbg_state}, {1'b0, 1'b1, ST_IDLE});
    tick();
    ulpi_dir = 1'b0;
    tick();
    pkt_latch = 1'b1; pkt_byte = 8'h4D; ulpi_nxt = 1'b1;
    #2;
    chk("arb_pkt_first", {pkt_cts, ulpi_dout, pkt_nxt, ulpi_stp}, {1'b1, 8'h4D, 1'b1, 1'b0});
    tick();
    pkt_latch = 1'b0; pkt_stp = 1'b1; ulpi_nxt = 1'b0;
    #2;
    chk("pkt_stp_pass", {ulpi_stp, ulpi_dout, pkt_cts, pkt_nxt}, {1'b1, 8'h00, 1'b1, 1'b0});
    tick();
    pkt_stp = 1'b0;
    #2;
    chk("pkt_turn", {pkt_cts, ulpi_stp, ulpi_dout, dbg_state}, {1'b0, 1'b0, 8'h00, ST_TURN});
    tick();
    #2;
    chk("arb_idle", pkt_cts, 1'b0);
    tick();
    reg_service(1'b0, 8'h00, 0);
    // fair must be clear again: both pending at IDLE -> packet wins
    ulpi_dir = 1'b1;
    reg_req = 1'b1; reg_rd = 1'b0; reg_addr = 6'h02; reg_wdata = 8'h44;
    exp_q.push_back(8'h82);
    exp_q.push_back(8'h44);
    tick();
    reg_req = 1'b0;
    tick();
    ulpi_dir = 1'b0;
    tick();
    #2;
    chk("fair_cleared", {pkt_cts, dbg_state}, {1'b1, ST_PKT});
    pkt_stp = 1'b1;
    tick();
    pkt_stp = 1'b0; pkt_req = 1'b0;
    tick();
    tick();
    reg_service(1'b0, 8'h00, 0);

    // PHY takes the bus during REG_CMD: abort, then reissue
    reg_issue(1'b0, 6'h0B, 8'h12, 8'h8B, 8'h12);
    tick();
    ulpi_dir = 1'b1;
    #2;
    chk("abort_dout", {ulpi_stp, ulpi_dout}, 9'h000);
    tick();
    #2;
    chk("abort_idle", {dbg_state, reg_busy, reg_done}, {ST_IDLE, 1'b1, 1'b0});
    tick();
    ulpi_dir = 1'b0;
    #2;
    chk("abort_hold", {dbg_state, reg_done}, {ST_IDLE, 1'b0});
    tick();
    reg_service(1'b0, 8'h00, 1);

    // timeouts in REG_CMD and in REG_WDATA
    tmo_seq(0, 6'h10, 8'h77);
    tmo_seq(1, 6'h11, 8'h66);

    // reset during REG_WDATA
    reg_issue(1'b0, 6'h20, 8'h99, 8'hA0, 8'h99);
    tick();
    ulpi_nxt = 1'b1;
    #2;
    chk("rst_cmd", ulpi_dout, exp_q.pop_front());
    tick();
    ulpi_nxt = 1'b0;
    #2;
    chk("rst_wdata", ulpi_dout, exp_q.pop_front());
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    chk("rst_state", {dbg_state, reg_busy, ulpi_stp, reg_done, reg_rdata},
        {ST_IDLE, 1'b0, 1'b0, 1'b0, 8'h00});
    last_rdata = 8'h00;
    tick();
    #2;
    chk("rst_no_done", {reg_done, reg_busy}, 2'b00);
    reg_issue(1'b1, 6'h05, 8'h00, 8'hC5, 8'h3C);
    tick();
    reg_service(1'b1, 8'h3C, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
